// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback for the 3-bit-opcode
// CPU, with a per-access memory stall timeout that traps into a sticky FAULT state.
module mc_control_fsm #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             pc_en,
  output logic             pc_src,
  output logic             ab_load,
  output logic [1:0]       alu_op,
  output logic             alu_load,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExec   = 4'd2,
    StWbAlu  = 4'd3,
    StMemLd  = 4'd4,
    StWbMem  = 4'd5,
    StMemSt  = 4'd6,
    StBranch = 4'd7,
    StJump   = 4'd8,
    StHalt   = 4'd9,
    StFault  = 4'd10
  } state_e;

  localparam int unsigned WaitW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WaitW-1:0] WaitLast = (WAIT_LIMIT == 0) ? '0 : WaitW'(WAIT_LIMIT - 1);

  state_e           r_state;
  logic [WaitW-1:0] r_wait;
  logic [CNT_W-1:0] r_retired;
  logic [1:0]       r_alu_sel;
  logic             r_halted;
  logic             r_fault;
  logic             w_timeout;

  // Last allowed request cycle still without ready: the access has stalled too long.
  assign w_timeout = (WAIT_LIMIT != 0) && !mem_ready && (r_wait == WaitLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StFetch;
      r_wait    <= '0;
      r_retired <= '0;
      r_alu_sel <= 2'b00;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_wait <= '0;
      case (r_state)
        StFetch, StMemLd, StMemSt: begin
          if (mem_ready) begin
            case (r_state)
              StFetch: r_state <= StDecode;
              StMemLd: r_state <= StWbMem;
              default: begin
                r_state   <= StFetch;
                r_retired <= r_retired + CNT_W'(1);
              end
            endcase
          end else if (w_timeout) begin
            r_state <= StFault;
            r_fault <= 1'b1;
          end else begin
            r_wait <= r_wait + WaitW'(1);
          end
        end
        StDecode: begin
          r_alu_sel <= opcode[1:0];
          case (opcode)
            3'd0:    r_state <= StMemLd;
            3'd1:    r_state <= StMemSt;
            3'd2:    r_state <= StBranch;
            3'd3:    r_state <= StJump;
            3'd7: begin
              r_state   <= StHalt;
              r_halted  <= 1'b1;
              r_retired <= r_retired + CNT_W'(1);
            end
            default: r_state <= StExec;
          endcase
        end
        StExec: r_state <= StWbAlu;
        StWbAlu, StWbMem, StBranch, StJump: begin
          r_state   <= StFetch;
          r_retired <= r_retired + CNT_W'(1);
        end
        StHalt:  r_state <= StHalt;
        StFault: r_state <= StFault;
        default: begin
          r_state <= StFault;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  // Datapath strobes decode from the current state; everything is forced low during reset.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    mdr_load = 1'b0;
    pc_en    = 1'b0;
    pc_src   = 1'b0;
    ab_load  = 1'b0;
    alu_op   = 2'b00;
    alu_load = 1'b0;
    rf_we    = 1'b0;
    rf_wsel  = 1'b0;
    if (rst_n) begin
      case (r_state)
        StFetch: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
          pc_en   = mem_ready;
        end
        StDecode: ab_load = 1'b1;
        StExec: begin
          alu_op   = r_alu_sel;
          alu_load = 1'b1;
        end
        StWbAlu: rf_we = 1'b1;
        StMemLd: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mdr_load = mem_ready;
        end
        StWbMem: begin
          rf_we   = 1'b1;
          rf_wsel = 1'b1;
        end
        StMemSt: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
        end
        StBranch: begin
          alu_op = 2'b11;
          pc_en  = zero;
          pc_src = zero;
        end
        StJump: begin
          pc_en  = 1'b1;
          pc_src = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted  = r_halted;
  assign fault   = r_fault;
  assign retired = r_retired;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: random instruction streams with random memory stalls,
// per-instruction expectations derived from the latency/strobe rules, plus reset/timeout cases.
module tb_mc_control_fsm;

  localparam int unsigned WaitLimit = 15;
  localparam int unsigned CntW      = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      opcode = 3'd0;
  logic            zero = 1'b0;
  logic            mem_ready;
  logic            mem_req, mem_we, addr_sel, ir_load, mdr_load, pc_en, pc_src, ab_load;
  logic [1:0]      alu_op;
  logic            alu_load, rf_we, rf_wsel, halted, fault;
  logic [CntW-1:0] retired;
  logic [3:0]      state;

  mc_control_fsm #(
    .WAIT_LIMIT(WaitLimit),
    .CNT_W     (CntW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .zero     (zero),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .addr_sel (addr_sel),
    .ir_load  (ir_load),
    .mdr_load (mdr_load),
    .pc_en    (pc_en),
    .pc_src   (pc_src),
    .ab_load  (ab_load),
    .alu_op   (alu_op),
    .alu_load (alu_load),
    .rf_we    (rf_we),
    .rf_wsel  (rf_wsel),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Per-instruction summary: cycle count and how many cycles each strobe was seen.
  typedef struct {
    int cyc; int req; int asel; int we; int pcen; int redir; int rfwe; int rfmem;
    int aluld; int aluop; int pass; int mdr; int irld; int abld;
  } rec_t;

  function automatic rec_t model(input int op, input bit z, input int fw, input int mw);
    rec_t r;
    bit is_mem = (op == 0 || op == 1);
    bit is_alu = (op >= 4 && op <= 6);
    r.cyc   = (fw + 1) + 1 + (is_alu ? 2 : 0) + (is_mem ? mw + 1 : 0) + (op == 0 ? 1 : 0)
            + ((op == 2 || op == 3) ? 1 : 0);
    r.req   = (fw + 1) + (is_mem ? mw + 1 : 0);
    r.asel  = is_mem ? mw + 1 : 0;
    r.we    = (op == 1) ? mw + 1 : 0;
    r.redir = (op == 3 || (op == 2 && z)) ? 1 : 0;
    r.pcen  = 1 + r.redir;
    r.rfwe  = (is_alu || op == 0) ? 1 : 0;
    r.rfmem = (op == 0) ? 1 : 0;
    r.aluld = is_alu ? 1 : 0;
    r.aluop = is_alu ? op - 4 : 0;
    r.pass  = (op == 2) ? 1 : 0;
    r.mdr   = (op == 0) ? 1 : 0;
    r.irld  = 1;
    r.abld  = 1;
    return r;
  endfunction

  // Memory/decoder responder: wait counts per access, opcode/zero per fetched instruction.
  int unsigned wq[$];
  logic [2:0]  oq[$];
  bit          zq[$];
  int unsigned cnt = 0;
  int unsigned cur_target = 32'hFFFF_FFFF;
  bit          resp_en = 1'b0;
  logic        man_ready = 1'b1;
  bit          hs_mem, hs_wait, hs_ir;

  assign mem_ready = resp_en ? (mem_req && (cnt == cur_target)) : man_ready;

  always @(negedge clk) begin
    hs_mem  = rst_n && mem_req && mem_ready;
    hs_wait = rst_n && mem_req && !mem_ready;
    hs_ir   = rst_n && ir_load;
  end

  always @(posedge clk) begin
    #1;
    if (resp_en) begin
      if (hs_ir && oq.size() > 0) begin
        opcode = oq.pop_front();
        zero   = zq.pop_front();
      end
      if (hs_mem) begin
        if (wq.size() > 0) void'(wq.pop_front());
        cnt = 0;
      end else if (hs_wait) begin
        cnt++;
      end
      cur_target = (wq.size() > 0) ? wq[0] : 32'hFFFF_FFFF;
    end
    hs_mem  = 1'b0;
    hs_wait = 1'b0;
    hs_ir   = 1'b0;
  end

  // Monitor: on each retire event, pop the expected record and compare the accumulated strobes.
  rec_t        exp_q[$];
  rec_t        acc;
  rec_t        mon_e;
  bit          mon_en = 1'b0;
  logic [CntW-1:0] last_ret;
  int          mon_count;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (retired != last_ret) begin
        last_ret = retired;
        mon_count++;
        chk("retired_count", retired, mon_count % (1 << CntW));
        chk("retire_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("cycles", acc.cyc, mon_e.cyc);
          chk("mem_req_cycles", acc.req, mon_e.req);
          chk("addr_sel_cycles", acc.asel, mon_e.asel);
          chk("mem_we_cycles", acc.we, mon_e.we);
          chk("pc_en_cycles", acc.pcen, mon_e.pcen);
          chk("pc_redirect", acc.redir, mon_e.redir);
          chk("rf_we_cycles", acc.rfwe, mon_e.rfwe);
          chk("rf_wsel_mdr", acc.rfmem, mon_e.rfmem);
          chk("alu_load_cycles", acc.aluld, mon_e.aluld);
          chk("alu_op_exec", acc.aluop, mon_e.aluop);
          chk("alu_pass_cycles", acc.pass, mon_e.pass);
          chk("mdr_load_cycles", acc.mdr, mon_e.mdr);
          chk("ir_load_cycles", acc.irld, mon_e.irld);
          chk("ab_load_cycles", acc.abld, mon_e.abld);
        end
        acc = '{default: 0};
      end
      acc.cyc++;
      if (mem_req) acc.req++;
      if (mem_req && addr_sel) acc.asel++;
      if (mem_req && mem_we) acc.we++;
      if (pc_en) acc.pcen++;
      if (pc_en && pc_src) acc.redir++;
      if (rf_we) acc.rfwe++;
      if (rf_we && rf_wsel) acc.rfmem++;
      if (alu_load) begin
        acc.aluld++;
        acc.aluop = alu_op;
      end
      if (alu_op == 2'b11) acc.pass++;
      if (mdr_load) acc.mdr++;
      if (ir_load) acc.irld++;
      if (ab_load) acc.abld++;
    end
  end

  int prog_len;

  task automatic add_instr(input int op, input bit z, input int fw, input int mw);
    logic [2:0] op3;
    op3 = op[2:0];
    oq.push_back(op3);
    zq.push_back(z);
    wq.push_back(fw);
    if (op == 0 || op == 1) wq.push_back(mw);
    exp_q.push_back(model(op, z, fw, mw));
    prog_len++;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    wq.delete();
    oq.delete();
    zq.delete();
    exp_q.delete();
    cnt        = 0;
    cur_target = 32'hFFFF_FFFF;
    prog_len   = 0;
  endtask

  task automatic release_reset();
    cur_target = (wq.size() > 0) ? wq[0] : 32'hFFFF_FFFF;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WaitLimit - 1)) : 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int nwe;
    // Reset: every strobe low even with mem_ready high, state FETCH.
    man_ready = 1'b1;
    opcode    = 3'd7;
    zero      = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_strobes", {mem_req, mem_we, addr_sel, ir_load, mdr_load, pc_en, pc_src, ab_load,
                          alu_op, alu_load, rf_we, rf_wsel, halted, fault}, 0);
    chk("reset_state", state, 0);
    chk("reset_retired", retired, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("release_mem_req", mem_req, 1);
    chk("release_addr_sel", addr_sel, 0);
    rst_n = 1'b0;

    // Main run: directed corner instructions then a random stream, ending in HALT.
    do_reset();
    add_instr(4, 1'b0, 0, 0);
    add_instr(0, 1'b0, 0, 3);
    add_instr(2, 1'b1, 0, 0);
    add_instr(2, 1'b0, 0, 0);
    add_instr(1, 1'b0, 0, WaitLimit - 1);
    add_instr(5, 1'b1, WaitLimit - 1, 0);
    add_instr(6, 1'b0, 2, 0);
    add_instr(3, 1'b1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      add_instr($urandom_range(0, 6), 1'($urandom_range(0, 1)), rnd_wait(), rnd_wait());
    end
    add_instr(7, 1'b0, 1, 0);
    acc       = '{default: 0};
    last_ret  = '0;
    mon_count = 0;
    resp_en   = 1'b1;
    mon_en    = 1'b1;
    release_reset();
    for (int i = 0; i < 5000 && !halted; i++) @(negedge clk);
    chk("halt_reached", halted, 1);
    repeat (5) @(negedge clk);
    chk("all_retired", exp_q.size(), 0);
    chk("halt_state", state, 9);
    chk("halt_retired", retired, prog_len % (1 << CntW));
    chk("halt_no_fault", fault, 0);
    chk("halt_quiet", {mem_req, pc_en, rf_we, ir_load}, 0);

    // Timeout: a store whose memory never answers faults after WaitLimit request cycles.
    do_reset();
    add_instr(1, 1'b0, 0, 1_000_000);
    exp_q.delete();
    release_reset();
    nwe = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state == 4'd10) break;
      if (mem_we) nwe++;
    end
    chk("timeout_store_cycles", nwe, WaitLimit);
    chk("fault_state", state, 10);
    chk("fault_flag", fault, 1);
    chk("fault_retired", retired, 0);
    resp_en   = 1'b0;
    man_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("fault_sticky_state", state, 10);
    chk("fault_sticky_flag", fault, 1);
    chk("fault_quiet", {mem_req, mem_we, ir_load, pc_en, rf_we, halted}, 0);

    // Reset asserted mid-store drops the request at once and issues nothing afterwards.
    do_reset();
    add_instr(1, 1'b0, 0, 1_000_000);
    exp_q.delete();
    resp_en = 1'b1;
    release_reset();
    for (int i = 0; i < 20 && state != 4'd6; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("midst_store_active", {mem_req, mem_we}, 3);
    rst_n = 1'b0;
    #1;
    chk("midst_reset_drop", {mem_req, mem_we}, 0);
    chk("midst_reset_state", state, 0);
    resp_en   = 1'b0;
    man_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_abort_state", state, 0);
    chk("after_abort_writes", {mem_we, rf_we, pc_en}, 0);
    chk("after_abort_retired", retired, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
